// File: rtl/dual_mem_arbiter.sv
// Four-way memory arbiter (dcache0/1, icache0/1) onto one single-ported RAM, one word per grant.
// Optional round-robin tie-break between cores of the same class is enabled by defining ARB_RR_EN.

package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module dual_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        iREN,
  input  logic [ADDR_W-1:0] iaddr0,
  input  logic [ADDR_W-1:0] iaddr1,
  input  logic [1:0]        dREN,
  input  logic [1:0]        dWEN,
  input  logic [ADDR_W-1:0] daddr0,
  input  logic [ADDR_W-1:0] daddr1,
  input  logic [DATA_W-1:0] dstore0,
  input  logic [DATA_W-1:0] dstore1,
  input  logic [1:0]        ccwait,
  output logic [1:0]        iwait,
  output logic [1:0]        dwait,
  output logic [DATA_W-1:0] iload0,
  output logic [DATA_W-1:0] iload1,
  output logic [DATA_W-1:0] dload0,
  output logic [DATA_W-1:0] dload1,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              ramerr
);

  typedef enum logic {IDLE, XFER} state_t;
  // bit 1 = instruction class, bit 0 = core index
  typedef enum logic [1:0] {G_D0 = 2'b00, G_D1 = 2'b01, G_I0 = 2'b10, G_I1 = 2'b11} grant_t;

  state_t      r_state;
  grant_t      r_grant;

  logic [1:0]  w_dreq;
  logic        w_any;
  logic        w_tie;
  logic        w_dcore;
  logic        w_icore;
  grant_t      w_win;
  logic        w_gcore;
  logic        w_gins;
  logic        w_greq;
  logic        w_xfer;
  logic        w_done;
  logic        w_sticky;

  assign w_dreq = dREN | dWEN;
  assign w_any  = (|w_dreq) | (|iREN);

`ifdef ARB_RR_EN
  logic r_last;

  always_ff @(posedge CLK) begin
    if (RST)         r_last <= 1'b1;
    else if (w_done) r_last <= w_gcore;
  end

  assign w_tie = ~r_last;
`else
  assign w_tie = 1'b0;
`endif

  // Winner depends only on registered state and live requests, never on ramstate
  assign w_dcore = (&w_dreq) ? w_tie : w_dreq[1];
  assign w_icore = (&iREN)   ? w_tie : iREN[1];
  assign w_win   = (|w_dreq) ? grant_t'({1'b0, w_dcore}) : grant_t'({1'b1, w_icore});

  assign w_gcore  = r_grant[0];
  assign w_gins   = r_grant[1];
  assign w_greq   = w_gins ? iREN[w_gcore] : w_dreq[w_gcore];
  assign w_xfer   = (r_state == XFER) && !RST && w_greq;
  assign w_done   = w_xfer && ((ramstate == ACCESS) || (ramstate == ERROR));
  assign w_sticky = !w_gins && ccwait[w_gcore] && dWEN[w_gcore];
  assign ramerr   = w_done && (ramstate == ERROR);

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (w_xfer) begin
      if (w_gins) begin
        ramREN  = 1'b1;
        ramaddr = w_gcore ? iaddr1 : iaddr0;
      end else begin
        // A simultaneous read and write from one core is served as the write
        ramWEN   = dWEN[w_gcore];
        ramREN   = !dWEN[w_gcore];
        ramaddr  = w_gcore ? daddr1 : daddr0;
        ramstore = w_gcore ? dstore1 : dstore0;
      end
    end
  end

  always_comb begin
    iwait = iREN;
    dwait = w_dreq;
    if (w_done) begin
      if (w_gins) iwait[w_gcore] = 1'b0;
      else        dwait[w_gcore] = 1'b0;
    end
  end

  assign iload0 = ramload;
  assign iload1 = ramload;
  assign dload0 = ramload;
  assign dload1 = ramload;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_grant <= G_D0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_win;
            r_state <= XFER;
          end
        end
        XFER: begin
          // A held writeback keeps the grant so its second word follows with no bubble
          if (!w_greq || (w_done && !w_sticky)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_mem_arbiter.sv
// Directed bench for dual_mem_arbiter; expected orders follow ARB_RR_EN when it is defined.

module tb_dual_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct {
    int          src;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } xfer_t;

  logic              CLK = 1'b0;
  logic              RST;
  logic [1:0]        iREN, dREN, dWEN, ccwait, iwait, dwait;
  logic [ADDR_W-1:0] iaddr0, iaddr1, daddr0, daddr1, ramaddr;
  logic [DATA_W-1:0] dstore0, dstore1, iload0, iload1, dload0, dload1, ramstore, ramload;
  logic              ramREN, ramWEN, ramerr;
  ramstate_t         ramstate;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int cnt = 0;
  int busy_n = 0;
  int n_ramerr = 0;
  bit err_mode = 1'b0;
  int rem [4];
  xfer_t log_q [$];

  dual_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr0(iaddr0), .iaddr1(iaddr1),
    .dREN(dREN), .dWEN(dWEN), .daddr0(daddr0), .daddr1(daddr1),
    .dstore0(dstore0), .dstore1(dstore1), .ccwait(ccwait),
    .iwait(iwait), .dwait(dwait),
    .iload0(iload0), .iload1(iload1), .dload0(dload0), .dload1(dload1),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
  );

  always #5 CLK = ~CLK;

  // RAM model: busy_n BUSY cycles per word, then ACCESS (or ERROR)
  always @(posedge CLK) begin
    if (!(ramREN | ramWEN) || ramstate == ACCESS || ramstate == ERROR) cnt <= 0;
    else cnt <= cnt + 1;
  end

  always_comb begin
    ramstate = FREE;
    if (ramREN | ramWEN) begin
      if (cnt < busy_n) ramstate = BUSY;
      else if (err_mode) ramstate = ERROR;
      else ramstate = ACCESS;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sample this cycle, advance one clock, then let served requestors advance or withdraw
  task automatic tick();
    logic [3:0] srv;
    xfer_t e;
    #1;
    srv = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      if ((dREN[k] | dWEN[k]) && !dwait[k]) srv[k] = 1'b1;
      if (iREN[k] && !iwait[k]) srv[2+k] = 1'b1;
    end
    if (ramerr) n_ramerr++;
    for (int s = 0; s < 4; s++) begin
      if (srv[s]) begin
        e.src = s; e.we = ramWEN; e.addr = ramaddr; e.data = ramstore;
        e.err = ramerr; e.cyc = cyc;
        log_q.push_back(e);
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    for (int s = 0; s < 4; s++) begin
      if (srv[s]) begin
        rem[s]--;
        case (s)
          0: daddr0 = daddr0 + 32'd4;
          1: daddr1 = daddr1 + 32'd4;
          2: iaddr0 = iaddr0 + 32'd4;
          default: iaddr1 = iaddr1 + 32'd4;
        endcase
        if (rem[s] == 0) begin
          case (s)
            0: begin dREN[0] = 1'b0; dWEN[0] = 1'b0; end
            1: begin dREN[1] = 1'b0; dWEN[1] = 1'b0; end
            2: iREN[0] = 1'b0;
            default: iREN[1] = 1'b0;
          endcase
        end
      end
    end
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int b;
    b = 0;
    while (log_q.size() < n && b < budget) begin
      tick();
      b++;
    end
    check({tag, "_count"}, log_q.size(), n);
  endtask

  function automatic xfer_t get(input int k);
    xfer_t e;
    e.src = -1; e.we = 1'bx; e.addr = 32'hFFFF_FFFF; e.data = 32'hFFFF_FFFF;
    e.err = 1'bx; e.cyc = -1;
    if (k < log_q.size()) e = log_q[k];
    return e;
  endfunction

  task automatic new_test();
    log_q.delete();
    for (int s = 0; s < 4; s++) rem[s] = 100;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    xfer_t e, e1;
    int lows, low_at;
    RST = 1'b1;
    iREN = 2'b00; dREN = 2'b00; dWEN = 2'b00; ccwait = 2'b00;
    iaddr0 = '0; iaddr1 = '0; daddr0 = 32'h1234; daddr1 = '0;
    dstore0 = 32'h1111_1111; dstore1 = 32'h2222_2222; ramload = '0;
    new_test();

    // Reset: no strobes, waits mirror requests
    iREN = 2'b10; dWEN = 2'b01;
    tick();
    check("rst_ren", 32'(ramREN), 0);
    check("rst_wen", 32'(ramWEN), 0);
    check("rst_addr", ramaddr, 0);
    check("rst_store", ramstore, 0);
    check("rst_err", 32'(ramerr), 0);
    check("rst_iwait", 32'(iwait), 32'h2);
    check("rst_dwait", 32'(dwait), 32'h1);
    iREN = 2'b00; dWEN = 2'b00;
    tick();
    RST = 1'b0;
    tick();

    // Single data read, two BUSY cycles before ACCESS
    new_test();
    busy_n = 2;
    dREN = 2'b01; daddr0 = 32'h100; ramload = 32'hDEAD_BEEF;
    lows = 0; low_at = 0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      if (c == 2) begin
        check("rd_ren", 32'(ramREN), 1);
        check("rd_addr", ramaddr, 32'h100);
      end
      if (dwait[0] == 1'b0) begin
        lows++;
        low_at = c;
        check("rd_dload0", dload0, 32'hDEAD_BEEF);
      end
      tick();
    end
    dREN = 2'b00;
    #1;
    check("rd_low_count", lows, 1);
    check("rd_low_cycle", low_at, 4);
    check("rd_ren_after", 32'(ramREN), 0);
    tick(); tick();

    // Data beats instruction, one bubble between grants
    new_test();
    busy_n = 0;
    rem[1] = 1; rem[2] = 1;
    iREN = 2'b01; iaddr0 = 32'h40; dREN = 2'b10; daddr1 = 32'h80;
    wait_log(2, 20, "dvi");
    e = get(0); e1 = get(1);
    check("dvi_first_src", e.src, 1);
    check("dvi_first_addr", e.addr, 32'h80);
    check("dvi_second_src", e1.src, 2);
    check("dvi_second_addr", e1.addr, 32'h40);
    check("dvi_gap", e1.cyc - e.cyc, 2);
    tick(); tick();

    // Same-class write tie held over four grants
    do_reset();
    new_test();
    busy_n = 0;
    daddr0 = 32'h300; daddr1 = 32'h380;
    dWEN = 2'b11;
    wait_log(4, 40, "tie");
    dWEN = 2'b00;
`ifdef ARB_RR_EN
    e = get(0); check("tie_src0", e.src, 0); check("tie_addr0", e.addr, 32'h300);
    e = get(1); check("tie_src1", e.src, 1); check("tie_addr1", e.addr, 32'h380);
    check("tie_data1", e.data, 32'h2222_2222);
    e = get(2); check("tie_src2", e.src, 0); check("tie_addr2", e.addr, 32'h304);
    e = get(3); check("tie_src3", e.src, 1); check("tie_addr3", e.addr, 32'h384);
`else
    e = get(0); check("tie_src0", e.src, 0); check("tie_addr0", e.addr, 32'h300);
    e = get(1); check("tie_src1", e.src, 0); check("tie_addr1", e.addr, 32'h304);
    check("tie_data1", e.data, 32'h1111_1111);
    e = get(2); check("tie_src2", e.src, 0); check("tie_addr2", e.addr, 32'h308);
    e = get(3); check("tie_src3", e.src, 0); check("tie_addr3", e.addr, 32'h30C);
`endif
    check("tie_we", 32'(e.we), 1);
    tick(); tick();

    // Sticky two-word writeback while core 1 waits to read
    new_test();
    busy_n = 0;
    rem[0] = 2; rem[1] = 1;
    daddr0 = 32'h200; daddr1 = 32'h500;
    ccwait = 2'b01; dWEN = 2'b01; dREN = 2'b10;
    wait_log(3, 30, "wb");
    ccwait = 2'b00;
    e = get(0); e1 = get(1);
    check("wb_src0", e.src, 0);
    check("wb_addr0", e.addr, 32'h200);
    check("wb_we0", 32'(e.we), 1);
    check("wb_src1", e1.src, 0);
    check("wb_addr1", e1.addr, 32'h204);
    check("wb_gap", e1.cyc - e.cyc, 1);
    e = get(2);
    check("wb_src2", e.src, 1);
    check("wb_addr2", e.addr, 32'h500);
    tick(); tick();

    // Instruction request withdrawn during BUSY
    new_test();
    busy_n = 3;
    rem[3] = 1;
    iaddr1 = 32'h600; iREN = 2'b10;
    tick();
    check("wd_ren_busy", 32'(ramREN), 1);
    check("wd_addr", ramaddr, 32'h600);
    iREN = 2'b00;
    #1;
    check("wd_ren_drop", 32'(ramREN), 0);
    tick();
    iREN = 2'b10;
    #1;
    check("wd_idle", 32'(ramREN), 0);
    tick();
    check("wd_regrant", 32'(ramREN), 1);
    wait_log(1, 20, "wd");
    e = get(0);
    check("wd_src", e.src, 3);
    tick(); tick();

    // Reset mid-transfer after core 0 was last served
    new_test();
    busy_n = 0;
    rem[0] = 1;
    daddr0 = 32'h800; dREN = 2'b01;
    wait_log(1, 20, "pre");
    tick(); tick();
    new_test();
    busy_n = 3;
    daddr0 = 32'h900; daddr1 = 32'hA00; dREN = 2'b11;
    tick();
    check("mid_strobe", 32'(ramREN), 1);
    RST = 1'b1;
    #1;
    check("mid_rst_ren", 32'(ramREN), 0);
    check("mid_rst_dwait", 32'(dwait), 32'h3);
    tick();
    RST = 1'b0;
    busy_n = 0;
    new_test();
    rem[0] = 1; rem[1] = 1;
    #1;
    check("mid_after_ren", 32'(ramREN), 0);
    check("mid_after_wen", 32'(ramWEN), 0);
    wait_log(2, 20, "mid");
    e = get(0); e1 = get(1);
    check("mid_first_src", e.src, 0);
    check("mid_second_src", e1.src, 1);
    tick(); tick();

    // ERROR completion on a read
    new_test();
    check("err_none_before", n_ramerr, 0);
    busy_n = 1; err_mode = 1'b1;
    rem[2] = 1;
    iaddr0 = 32'h700; iREN = 2'b01;
    wait_log(1, 20, "err");
    err_mode = 1'b0;
    tick(); tick();
    e = get(0);
    check("err_src", e.src, 2);
    check("err_addr", e.addr, 32'h700);
    check("err_same_cycle", 32'(e.err), 1);
    check("err_pulse_len", n_ramerr, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/dual_mem_arbiter.md
# dual_mem_arbiter

Arbitrates the four memory requestors of the dual-core system (dcache0, dcache1, icache0, icache1) onto the single-ported RAM interface, one word per grant. Sits directly downstream of the coherency controller and both caches. Its per-core `dwait` outputs are the `dwait` inputs the coherency controller uses to sequence two-word snoop writebacks. The block holds a grant across a coherency-driven writeback so both words reach RAM back-to-back.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `iREN` in 2: instruction read request, bit k = core k.
- `iaddr0`, `iaddr1` in ADDR_W: instruction addresses.
- `dREN`, `dWEN` in 2: data read / write requests.
- `daddr0`, `daddr1` in ADDR_W: data addresses.
- `dstore0`, `dstore1` in DATA_W: write data.
- `ccwait` in 2: coherency hold per core; marks a snoop writeback in progress.
- `iwait`, `dwait` out 2: requestor stall, bit k = core k.
- `iload0`, `iload1`, `dload0`, `dload1` out DATA_W: read data.
- `ramREN`, `ramWEN` out 1: RAM strobes.
- `ramaddr` out ADDR_W, `ramstore` out DATA_W: RAM address and write data.
- `ramload` in DATA_W: RAM read data.
- `ramstate` in 2: `cpu_types_pkg::ramstate_t` (FREE, BUSY, ACCESS, ERROR).
- `ramerr` out 1: one-cycle pulse when a transfer ends with ERROR.

## Operation
- **State machine:** IDLE → XFER → IDLE. Registered `grant` in {D0, D1, I0, I1} and `last` (last-served core, 1 bit).
- **IDLE:** If any request is pending, choose a winner and load `grant` at the edge, then go to XFER. Otherwise stay in IDLE.
- **Priority:** Data beats instruction. Within a class, ARB_RR_EN picks the core ≠ `last` when both request (see Configuration).
- **Same-core conflict:** If dREN and dWEN are both high for the same core, treat it as a write.
- **XFER:** Drive `ramaddr`, `ramstore`, `ramREN`/`ramWEN` combinationally from the granted source's live inputs.
- **On ACCESS:**
  - Deassert the granted wait in that same cycle. All other waits stay high.
  - Set `last` to the granted core.
  - Go to IDLE, unless sticky-hold applies.
- **Sticky-hold:** If the granted source is Dk, `ccwait[k]`=1 and `dWEN[k]`=1 in the ACCESS cycle, stay in XFER with the same grant. This keeps the writeback's second word uninterrupted.
- **ERROR:** Treated as ACCESS (wait released, load data undefined), plus `ramerr`=1 for that cycle.
- **Request withdrawn in XFER:** If the granted source drops its request before ACCESS, drop the RAM strobes in that cycle and return to IDLE next edge. `last` is unchanged.
- **Wait outputs:**
  - Every wait bit = its request bit, except the granted bit during its ACCESS/ERROR cycle.
  - A source with no request has wait 0.
- **Load outputs:** `iload*`/`dload*` = `ramload`, passed through to all load outputs unconditionally.

## Timing
- **Reset:** State IDLE, `grant`=D0 (unused), `last`=1 so core 0 wins the first tie. Outputs during reset: `ramREN`=`ramWEN`=0, `ramaddr`=0, `ramstore`=0, `ramerr`=0, waits = request bits.
- **Reset mid-XFER:** Strobes are low in the cycle after the reset edge. No wait is released by a transfer that is cut off this way.
- **Latency:** Request sampled in IDLE at cycle N. RAM strobes driven in N+1. Wait low in the first cycle with ACCESS, at the earliest N+1.
- **Inter-grant bubble:** One IDLE cycle between non-sticky grants.
- **Sticky-hold:** Consecutive writeback words need no bubble.
- **Arbitration inputs:** Purely registered state plus current requests. There is no combinational path from `ramstate` to the next grant.

## Configuration
- **`ARB_RR_EN` defined:** Same-class ties go to the core ≠ `last`.
- **Undefined:** Fixed priority: D0 > D1 > I0 > I1, and `last` is unused.
- Sticky-hold behaves identically either way.

## Test plan
- **Single data read:** dREN=01, daddr0=0x100, RAM ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF. Expect dwait[0] low in exactly one cycle, that cycle being cycle 4, with dload0=0xDEADBEEF.
- **Data over instruction:** iREN=01 and dREN=10 asserted together. Expect D1 served first, then I0 after one bubble.
- **Round-robin tie:** dWEN=11 held for 4 grants with single-cycle ACCESS. Expect ARB_RR_EN order 0,1,0,1; without the macro, 0,0,0,0.
- **Sticky writeback:** ccwait=01, dWEN=01, two words to 0x200/0x204 while dREN[1]=1. Expect both writes with no D1 grant between them and no bubble, then D1 served.
- **Withdraw and reset:**
  - iREN[1] dropped during BUSY: expect `ramREN`=0 in that cycle and IDLE next cycle.
  - RST asserted mid-XFER: expect strobes 0 one cycle later and core 0 winning the next tie.
- **ERROR:** ramstate=ERROR on a read. Expect `ramerr` pulse of 1 cycle with the wait released in the same cycle.
